alu_arbiter: RTL and testbench

- Shares the single registered-output ALU between two requesters: port 0 is the integer pipeline EX issue, port 1 is the address/auxiliary unit.
- Arbitrates per cycle and drives the selected operands and control fields onto the ALU inputs.
- Tracks which port owns the in-flight operation and routes the ALU's registered result back to that port one cycle later.
- Sustains one operation per cycle.

---
 rtl/alu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Shares one registered-output ALU between two requesters
//             (port 0 = integer EX issue, port 1 = address/aux unit).
//             Picks at most one requester per cycle, drives its operands and
//             control fields onto the ALU inputs, and routes the ALU's
//             registered result back to the owning port one cycle later.
//             Sustains one operation per cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK, rst_n            clock, asynchronous active-low reset
//    hold, flush           stall / kill: no grant in a cycle where either is 1
//    reqX_valid/ready      request handshake, X = 0,1 (ready = granted now)
//    reqX_rs1/rs2/op       operands and {alu_ctrl, funct3, funct7_5, sub}
//    alu_*                 combinational drive to the shared ALU
//    alu_result/overflow   the ALU's registered outputs
//    rspX_valid            one-cycle response strobe for port X
//    rsp_result            ALU result (pass-through)
//    rsp_overflow          ALU overflow, masked when rsp_err is set
//    rsp_err               the responding op carried an illegal alu_ctrl
//    grant_cnt             free-running count of accepted ops (wraps)
//  Build option
//    ALU_ARB_FIXED_PRIO_EN : port 0 always wins contention; no round-robin
//                            state is kept. Undefined: round-robin.
// ============================================================================
module alu_arbiter #(
  parameter int         XLEN      = 32,
  parameter logic [2:0] IDLE_CTRL = 3'b111
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [7:0]      req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [7:0]      req1_op,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  output logic [2:0]      alu_ctrl,
  output logic [2:0]      alu_funct3,
  output logic            alu_funct7_5,
  output logic            alu_sub,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_overflow,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_overflow,
  output logic            rsp_err,
  output logic [15:0]     grant_cnt
);

  // alu_ctrl codes 101..111 are not real ALU operations.
  localparam logic [2:0] c_first_illegal_ctrl = 3'b101;

  logic            w_eligible;
  logic            w_pick0;
  logic            w_pick1;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_grant_any;
  logic            w_illegal;
  logic [7:0]      w_sel_op;
  logic [XLEN-1:0] w_sel_rs1;
  logic [XLEN-1:0] w_sel_rs2;

  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic            rsp_err_q,    rsp_err_d;
  logic [15:0]     grant_cnt_q,  grant_cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic            rr_last_q,    rr_last_d;
`endif

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  always_comb begin
    w_pick0 = req0_valid;
    w_pick1 = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_pick1 = 1'b0;
`else
      // rr_last holds the previous winner; the other port goes this time.
      w_pick0 = rr_last_q;
      w_pick1 = ~rr_last_q;
`endif
    end
  end

  // rst_n is folded in so nothing is granted (and the ALU sees idle) while
  // the block is held in reset.
  assign w_eligible  = ~hold & ~flush & rst_n;
  assign w_grant0    = w_eligible & w_pick0;
  assign w_grant1    = w_eligible & w_pick1;
  assign w_grant_any = w_grant0 | w_grant1;

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;

  // --------------------------------------------------------------------------
  // ALU drive
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_op  = 8'd0;
    w_sel_rs1 = '0;
    w_sel_rs2 = '0;
    if (w_grant0) begin
      w_sel_op  = req0_op;
      w_sel_rs1 = req0_rs1;
      w_sel_rs2 = req0_rs2;
    end else if (w_grant1) begin
      w_sel_op  = req1_op;
      w_sel_rs1 = req1_rs1;
      w_sel_rs2 = req1_rs2;
    end
  end

  // IDLE_CTRL is a non-updating code, so the ALU result register holds on
  // idle cycles.
  assign alu_ctrl     = w_grant_any ? w_sel_op[7:5] : IDLE_CTRL;
  assign alu_funct3   = w_sel_op[4:2];
  assign alu_funct7_5 = w_sel_op[1];
  assign alu_sub      = w_sel_op[0];
  assign alu_rs1      = w_sel_rs1;
  assign alu_rs2      = w_sel_rs2;

  assign w_illegal    = (w_sel_op[7:5] >= c_first_illegal_ctrl);

  // --------------------------------------------------------------------------
  // Response tracking
  // --------------------------------------------------------------------------
  always_comb begin
    rsp0_valid_d = w_grant0;
    rsp1_valid_d = w_grant1;
    rsp_err_d    = w_grant_any & w_illegal;
    grant_cnt_d  = grant_cnt_q + {15'd0, w_grant_any};
`ifndef ALU_ARB_FIXED_PRIO_EN
    rr_last_d    = w_grant_any ? w_grant1 : rr_last_q;
`endif
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      grant_cnt_q  <= 16'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      // Start as if port 1 won last, so port 0 takes the first contention.
      rr_last_q    <= 1'b1;
`endif
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_err_q    <= rsp_err_d;
      grant_cnt_q  <= grant_cnt_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_last_q    <= rr_last_d;
`endif
    end
  end

  assign rsp0_valid   = rsp0_valid_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp_err      = rsp_err_q;
  assign grant_cnt    = grant_cnt_q;
  // The ALU result and overflow are already registered, so they line up with
  // the response strobes without further staging.
  assign rsp_result   = alu_result;
  assign rsp_overflow = alu_overflow & ~rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter. Includes a small registered
//             ALU model, a directed vector table, a reset-mid-operation
//             sequence and a randomized run against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam logic [7:0]  OP_ADD = 8'h00;           // {000,000,0,0}
  localparam logic [7:0]  OP_SUB = 8'h03;           // {000,000,1,1}
  localparam logic [7:0]  OP_SLT = 8'h48;           // {010,010,0,0}
  localparam logic [7:0]  OP_BAD = 8'hA0;           // {101,000,0,0}
  localparam logic [31:0] M1     = 32'hFFFF_FFFF;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n, hold, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [7:0]  req0_op, req1_op;
  logic [31:0] alu_rs1, alu_rs2;
  logic [2:0]  alu_ctrl, alu_funct3;
  logic        alu_funct7_5, alu_sub;
  logic [31:0] alu_result   = 32'd0;
  logic        alu_overflow = 1'b0;
  logic        rsp0_valid, rsp1_valid, rsp_overflow, rsp_err;
  logic [31:0] rsp_result;
  logic [15:0] grant_cnt;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.XLEN(32), .IDLE_CTRL(3'b111)) dut (
    .CLK(CLK), .rst_n(rst_n), .hold(hold), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_op(req1_op),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl),
    .alu_funct3(alu_funct3), .alu_funct7_5(alu_funct7_5), .alu_sub(alu_sub),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .grant_cnt(grant_cnt)
  );

  // Reference ALU behaviour: returns {overflow, result}.
  function automatic logic [32:0] ref_alu(input logic [7:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    r  = 32'd0;
    ov = 1'b0;
    case (op[7:5])
      3'd0: begin
        if (op[0]) begin
          r  = a - b;
          ov = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
          r  = a + b;
          ov = (a[31] == b[31]) && (r[31] != a[31]);
        end
      end
      3'd1:    r = a << b[4:0];
      3'd2:    r = (op[4:2] == 3'b011) ? {31'd0, a < b} : {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = (op[4:2] == 3'b100) ? (a ^ b) : (op[4:2] == 3'b110) ? (a | b) : (a & b);
      3'd4:    r = b;
      default: r = 32'd0;
    endcase
    return {ov, r};
  endfunction

  // Registered ALU: codes 101..111 do not update the result register.
  always @(posedge CLK) begin
    if (alu_ctrl < 3'd5)
      {alu_overflow, alu_result} <= ref_alu({alu_ctrl, alu_funct3, alu_funct7_5, alu_sub},
                                            alu_rs1, alu_rs2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  ctl;    // {v0, v1, hold, flush}
    logic [7:0]  op0;
    logic [31:0] a0, b0;
    logic [7:0]  op1;
    logic [31:0] a1, b1;
    logic [1:0]  rdy;    // {ready0, ready1}
    logic [2:0]  ctrl;
    logic [1:0]  rsp;    // response visible this cycle {rsp0, rsp1}
    logic [15:0] cnt;
    logic [1:0]  chk;    // {check result, check overflow}
    logic [31:0] res;
    logic        ovf;
    logic        err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  // Random-phase model state
  int          m_last, win, pr_port;
  logic [15:0] m_cnt;
  logic [7:0]  pr_op, e_op;
  logic [31:0] pr_a, pr_b, e_rs1, e_rs2;
  logic        p0_v, p1_v;
  logic [7:0]  p0_op, p1_op;
  logic [31:0] p0_a, p0_b, p1_a, p1_b;
  logic [32:0] e_ref;

  initial begin
    vecs[0]  = '{4'b1100, OP_SUB, 32'd10, 32'd3, OP_SLT, M1, 32'd1, 2'b10, 3'b000, 2'b00, 16'd0, 2'b00, 32'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b1100, OP_SUB, 32'd10, 32'd3, OP_SLT, M1, 32'd1, FP ? 2'b10 : 2'b01, FP ? 3'b000 : 3'b010, 2'b10, 16'd1, 2'b11, 32'd7, 1'b0, 1'b0};
    vecs[2]  = '{4'b1100, OP_SUB, 32'd10, 32'd3, OP_SLT, M1, 32'd1, 2'b10, 3'b000, FP ? 2'b10 : 2'b01, 16'd2, 2'b11, FP ? 32'd7 : 32'd1, 1'b0, 1'b0};
    vecs[3]  = '{4'b1100, OP_SUB, 32'd10, 32'd3, OP_SLT, M1, 32'd1, FP ? 2'b10 : 2'b01, FP ? 3'b000 : 3'b010, 2'b10, 16'd3, 2'b11, 32'd7, 1'b0, 1'b0};
    vecs[4]  = '{4'b1000, OP_ADD, 32'd5, 32'd7, 8'h00, 32'd0, 32'd0, 2'b10, 3'b000, FP ? 2'b10 : 2'b01, 16'd4, 2'b11, FP ? 32'd7 : 32'd1, 1'b0, 1'b0};
    vecs[5]  = '{4'b0100, 8'h00, 32'd0, 32'd0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 2'b01, 3'b000, 2'b10, 16'd5, 2'b11, 32'd12, 1'b0, 1'b0};
    vecs[6]  = '{4'b1000, OP_ADD, 32'd1, 32'd2, 8'h00, 32'd0, 32'd0, 2'b10, 3'b000, 2'b01, 16'd6, 2'b11, 32'h8000_0000, 1'b1, 1'b0};
    vecs[7]  = '{4'b1001, OP_ADD, 32'd1, 32'd2, 8'h00, 32'd0, 32'd0, 2'b00, 3'b111, 2'b10, 16'd7, 2'b11, 32'd3, 1'b0, 1'b0};
    vecs[8]  = '{4'b1110, OP_ADD, 32'd1, 32'd2, OP_SLT, M1, 32'd1, 2'b00, 3'b111, 2'b00, 16'd7, 2'b00, 32'd0, 1'b0, 1'b0};
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = '{4'b1100, OP_ADD, 32'd1, 32'd2, OP_SLT, M1, 32'd1, FP ? 2'b10 : 2'b01, FP ? 3'b000 : 3'b010, 2'b00, 16'd7, 2'b00, 32'd0, 1'b0, 1'b0};
    vecs[12] = '{4'b1000, OP_BAD, 32'd4, 32'd4, 8'h00, 32'd0, 32'd0, 2'b10, 3'b101, FP ? 2'b10 : 2'b01, 16'd8, 2'b11, FP ? 32'd3 : 32'd1, 1'b0, 1'b0};
    vecs[13] = '{4'b0000, 8'h00, 32'd0, 32'd0, 8'h00, 32'd0, 32'd0, 2'b00, 3'b111, 2'b10, 16'd9, 2'b01, 32'd0, 1'b0, 1'b1};
    vecs[14] = '{4'b0000, 8'h00, 32'd0, 32'd0, 8'h00, 32'd0, 32'd0, 2'b00, 3'b111, 2'b00, 16'd9, 2'b00, 32'd0, 1'b0, 1'b0};

    // ---------------- reset state ----------------
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_rs1 = 32'd9; req0_rs2 = 32'd9;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_rs1 = 32'd9; req1_rs2 = 32'd9;
    #2;
    chk("reset ready0", 32'(req0_ready), 32'd0);
    chk("reset ready1", 32'(req1_ready), 32'd0);
    chk("reset alu_ctrl", 32'(alu_ctrl), 32'd7);
    chk("reset alu_rs1", alu_rs1, 32'd0);
    chk("reset rsp0", 32'(rsp0_valid), 32'd0);
    chk("reset rsp1", 32'(rsp1_valid), 32'd0);
    chk("reset err", 32'(rsp_err), 32'd0);
    chk("reset cnt", 32'(grant_cnt), 32'd0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      {req0_valid, req1_valid, hold, flush} = vecs[i].ctl;
      req0_op = vecs[i].op0; req0_rs1 = vecs[i].a0; req0_rs2 = vecs[i].b0;
      req1_op = vecs[i].op1; req1_rs1 = vecs[i].a1; req1_rs2 = vecs[i].b1;
      e_rs1 = vecs[i].rdy[1] ? vecs[i].a0 : (vecs[i].rdy[0] ? vecs[i].a1 : 32'd0);
      @(negedge CLK);
      chk($sformatf("v%0d ready0", i), 32'(req0_ready), 32'(vecs[i].rdy[1]));
      chk($sformatf("v%0d ready1", i), 32'(req1_ready), 32'(vecs[i].rdy[0]));
      chk($sformatf("v%0d alu_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d alu_rs1", i), alu_rs1, e_rs1);
      chk($sformatf("v%0d rsp0", i), 32'(rsp0_valid), 32'(vecs[i].rsp[1]));
      chk($sformatf("v%0d rsp1", i), 32'(rsp1_valid), 32'(vecs[i].rsp[0]));
      chk($sformatf("v%0d grant_cnt", i), 32'(grant_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vecs[i].err));
      if (vecs[i].chk[1]) chk($sformatf("v%0d rsp_result", i), rsp_result, vecs[i].res);
      if (vecs[i].chk[0]) chk($sformatf("v%0d rsp_overflow", i), 32'(rsp_overflow), 32'(vecs[i].ovf));
      @(posedge CLK); #1;
    end

    // ---------------- reset in the middle of an operation ----------------
    // Port 0 wins, so without the reset port 1 would take the next contention.
    req0_valid = 1'b1; req0_op = OP_ADD; req0_rs1 = 32'd20; req0_rs2 = 32'd22;
    req1_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    @(negedge CLK);
    chk("rstmid ready0", 32'(req0_ready), 32'd1);
    @(posedge CLK); #1;
    req0_valid = 1'b0;
    chk("rstmid rsp0 before", 32'(rsp0_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid rsp0 dropped", 32'(rsp0_valid), 32'd0);
    chk("rstmid cnt cleared", 32'(grant_cnt), 32'd0);
    chk("rstmid alu_ctrl idle", 32'(alu_ctrl), 32'd7);
    @(posedge CLK); #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = OP_SUB; req0_rs1 = 32'd10; req0_rs2 = 32'd3;
    req1_valid = 1'b1; req1_op = OP_SLT; req1_rs1 = M1;     req1_rs2 = 32'd1;
    @(negedge CLK);
    chk("rstmid post ready0", 32'(req0_ready), 32'd1);
    chk("rstmid post ready1", 32'(req1_ready), 32'd0);
    @(posedge CLK); #1;

    // ---------------- randomized run against the model ----------------
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    m_last = 1; m_cnt = 16'd0; pr_port = -1; pr_op = 8'd0; pr_a = 32'd0; pr_b = 32'd0;
    p0_v = 1'b0; p1_v = 1'b0;
    p0_op = 8'd0; p1_op = 8'd0; p0_a = 32'd0; p0_b = 32'd0; p1_a = 32'd0; p1_b = 32'd0;
    for (int n = 0; n < 1500; n++) begin
      // Requesters hold a request stable until it is accepted.
      if (!p0_v && $urandom_range(0, 9) < 6) begin
        p0_v = 1'b1; p0_op = 8'($urandom); p0_a = $urandom; p0_b = $urandom;
      end
      if (!p1_v && $urandom_range(0, 9) < 6) begin
        p1_v = 1'b1; p1_op = 8'($urandom); p1_a = $urandom; p1_b = $urandom;
      end
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 11) == 0);
      req0_valid = p0_v; req0_op = p0_op; req0_rs1 = p0_a; req0_rs2 = p0_b;
      req1_valid = p1_v; req1_op = p1_op; req1_rs1 = p1_a; req1_rs2 = p1_b;

      win = -1;
      if (p0_v && p1_v) win = FP ? 0 : ((m_last == 0) ? 1 : 0);
      else if (p0_v)    win = 0;
      else if (p1_v)    win = 1;
      if (hold || flush) win = -1;
      e_op  = (win == 0) ? p0_op : (win == 1) ? p1_op : 8'hE0;
      e_rs1 = (win == 0) ? p0_a  : (win == 1) ? p1_a  : 32'd0;
      e_rs2 = (win == 0) ? p0_b  : (win == 1) ? p1_b  : 32'd0;

      @(negedge CLK);
      chk("rnd ready0", 32'(req0_ready), 32'(win == 0));
      chk("rnd ready1", 32'(req1_ready), 32'(win == 1));
      chk("rnd alu_op", 32'({alu_ctrl, alu_funct3, alu_funct7_5, alu_sub}), 32'(e_op));
      chk("rnd alu_rs1", alu_rs1, e_rs1);
      chk("rnd alu_rs2", alu_rs2, e_rs2);
      chk("rnd rsp0", 32'(rsp0_valid), 32'(pr_port == 0));
      chk("rnd rsp1", 32'(rsp1_valid), 32'(pr_port == 1));
      chk("rnd grant_cnt", 32'(grant_cnt), 32'(m_cnt));
      chk("rnd rsp_err", 32'(rsp_err), 32'(pr_port >= 0 && pr_op[7:5] >= 3'd5));
      if (pr_port >= 0) begin
        if (pr_op[7:5] >= 3'd5) begin
          chk("rnd err overflow", 32'(rsp_overflow), 32'd0);
        end else begin
          e_ref = ref_alu(pr_op, pr_a, pr_b);
          chk("rnd rsp_result", rsp_result, e_ref[31:0]);
          chk("rnd rsp_overflow", 32'(rsp_overflow), 32'(e_ref[32]));
        end
      end

      pr_port = win;
      pr_op = e_op; pr_a = e_rs1; pr_b = e_rs2;
      if (win >= 0) begin
        m_cnt  = m_cnt + 16'd1;
        m_last = win;
      end
      if (win == 0) p0_v = 1'b0;
      if (win == 1) p1_v = 1'b0;
      @(posedge CLK); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
